mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 61 ++++++
 rtl/mem_access_load_ext.sv | 31 +++
 rtl/mem_access.sv | 121 ++++++++++++
 tb/tb_mem_access.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: op codes, request lengths,
// FSM state encodings and small op-classification helpers.
package mem_access_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    LEN_BYTE = 2'd0,
    LEN_HALF = 2'd1,
    LEN_WORD = 2'd2
  } req_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_len(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return LEN_BYTE;
      OP_LH, OP_LHU, OP_SH: return LEN_HALF;
      default:              return LEN_WORD;
    endcase
  endfunction

  // Only the bytes covered by the access length reach the memory controller.
  function automatic logic [DATA_W-1:0] store_wdata(input logic [3:0] op,
                                                    input logic [DATA_W-1:0] data);
    case (op)
      OP_SB:   return {24'd0, data[7:0]};
      OP_SH:   return {16'd0, data[15:0]};
      default: return data;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      OP_LW, OP_SW:         return |addr_lo;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Combinational load extension: selects byte/half/word from returned data and
// sign- or zero-extends it according to the load op.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic signed [7:0]        byte_s;
  logic signed [15:0]       half_s;
  logic signed [DATA_W-1:0] byte_ext;
  logic signed [DATA_W-1:0] half_ext;

  always_comb begin
    byte_s   = rdata[7:0];
    half_s   = rdata[15:0];
    byte_ext = DATA_W'(byte_s);
    half_ext = DATA_W'(half_s);
    data     = rdata;
    case (op)
      OP_LB:   data = byte_ext;
      OP_LH:   data = half_ext;
      OP_LBU:  data = {24'd0, rdata[7:0]};
      OP_LHU:  data = {16'd0, rdata[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues load/store requests to memctrl and stalls
// the pipe until the ack. Define MEM_MISALIGN_CHK_EN to trap misaligned accesses.
module mem_access
  import mem_access_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [4:0]        ex_reg_addr,
  input  logic [DATA_W-1:0] ex_reg_data,
  input  logic              ex_if_write,
  input  logic [3:0]        ex_mem_op,
  input  logic [DATA_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        mem_reg_addr,
  output logic [DATA_W-1:0] mem_reg_data,
  output logic              if_write,
  output logic              mem_stall_req,
  output logic              mc_req_valid,
  output logic              mc_req_we,
  output logic [1:0]        mc_req_len,
  output logic [DATA_W-1:0] mc_req_addr,
  output logic [DATA_W-1:0] mc_req_wdata,
  input  logic              mc_ack,
  input  logic [DATA_W-1:0] mc_rdata,
  output logic              misalign_err
);

  state_e            state;
  state_e            state_next;
  logic              mem_op_act;
  logic              store_op;
  logic              bad_align;
  logic [4:0]        res_addr;
  logic [DATA_W-1:0] res_data;
  logic              res_we;
  logic [DATA_W-1:0] load_data;

  assign mem_op_act = (ex_mem_op != OP_NONE);
  assign store_op   = is_store(ex_mem_op);

  mem_load_ext u_load_ext (
    .op    (ex_mem_op),
    .rdata (mc_rdata),
    .data  (load_data)
  );

`ifdef MEM_MISALIGN_CHK_EN
  assign bad_align = misaligned(ex_mem_op, ex_mem_addr[1:0]);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      misalign_err <= 1'b0;
    end else if (rdy_in && (state == ST_IDLE) && mem_op_act && bad_align) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign bad_align    = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else if (rdy_in) begin
      state <= state_next;
    end
  end

  // Result latch: captured on ack in WAIT, or cleared when a misaligned op is trapped.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      res_addr <= '0;
      res_data <= '0;
      res_we   <= 1'b0;
    end else if (rdy_in) begin
      if ((state == ST_IDLE) && mem_op_act && bad_align) begin
        res_addr <= '0;
        res_data <= '0;
        res_we   <= 1'b0;
      end else if ((state == ST_WAIT) && mc_ack) begin
        res_addr <= store_op ? 5'd0 : ex_reg_addr;
        res_data <= store_op ? '0 : load_data;
        res_we   <= store_op ? 1'b0 : ex_if_write;
      end
    end
  end

  always_comb begin
    state_next    = state;
    mem_stall_req = mem_op_act && (state != ST_DONE) && !rst_in;
    mc_req_valid  = (state == ST_WAIT);
    mc_req_we     = store_op;
    mc_req_len    = op_len(ex_mem_op);
    mc_req_addr   = ex_mem_addr;
    mc_req_wdata  = store_wdata(ex_mem_op, ex_store_data);
    mem_reg_addr  = '0;
    mem_reg_data  = '0;
    if_write      = 1'b0;

    case (state)
      ST_IDLE: if (mem_op_act) state_next = bad_align ? ST_DONE : ST_WAIT;
      ST_WAIT: if (mc_ack) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // Non-memory ops bypass the FSM entirely; memory ops expose the latched result in DONE.
    if (!mem_op_act) begin
      mem_reg_addr = ex_reg_addr;
      mem_reg_data = ex_reg_data;
      if_write     = ex_if_write;
    end else if (state == ST_DONE) begin
      mem_reg_addr = res_addr;
      mem_reg_data = res_data;
      if_write     = res_we;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// loads/stores checked against a behavioural model of the load/store rules.
module tb_mem_access;

  localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [4:0]  ex_reg_addr;
  logic [31:0] ex_reg_data;
  logic        ex_if_write;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr, ex_store_data;
  logic [4:0]  mem_reg_addr;
  logic [31:0] mem_reg_data;
  logic        if_write, mem_stall_req;
  logic        mc_req_valid, mc_req_we;
  logic [1:0]  mc_req_len;
  logic [31:0] mc_req_addr, mc_req_wdata;
  logic        mc_ack;
  logic [31:0] mc_rdata;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by the transaction driver
  int          obs_stall, obs_valid;
  logic        obs_stable, obs_timeout, obs_we;
  logic [1:0]  obs_len;
  logic [31:0] obs_addr, obs_wdata;
  logic [4:0]  obs_rd;
  logic [31:0] obs_data;
  logic        obs_wr;

  mem_access dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .ex_reg_addr(ex_reg_addr), .ex_reg_data(ex_reg_data), .ex_if_write(ex_if_write),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .mem_reg_addr(mem_reg_addr), .mem_reg_data(mem_reg_data), .if_write(if_write),
    .mem_stall_req(mem_stall_req), .mc_req_valid(mc_req_valid), .mc_req_we(mc_req_we),
    .mc_req_len(mc_req_len), .mc_req_addr(mc_req_addr), .mc_req_wdata(mc_req_wdata),
    .mc_ack(mc_ack), .mc_rdata(mc_rdata), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic m_store(input logic [3:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic logic [1:0] m_len(input logic [3:0] op);
    if (op == LB || op == LBU || op == SB) return 2'd0;
    if (op == LH || op == LHU || op == SH) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    if (op == SB) return d % 256;
    if (op == SH) return d % 65536;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] r);
    logic [31:0] b, h;
    b = r % 256;
    h = r % 65536;
    case (op)
      LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LBU:     return b;
      LHU:     return h;
      default: return r;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge with the FSM idle; returns after DONE has been observed.
  task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic ifw, input logic [31:0] rdata,
                        input int ack_after);
    obs_stall = 0; obs_valid = 0; obs_stable = 1'b1; obs_timeout = 1'b1;
    ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sdata;
    ex_reg_addr = rd; ex_if_write = ifw; ex_reg_data = $urandom;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!mem_stall_req) begin
        obs_rd = mem_reg_addr; obs_data = mem_reg_data; obs_wr = if_write;
        obs_timeout = 1'b0;
        break;
      end
      obs_stall++;
      if (mc_req_valid) begin
        obs_valid++;
        if (obs_valid == 1) begin
          obs_we = mc_req_we; obs_len = mc_req_len;
          obs_addr = mc_req_addr; obs_wdata = mc_req_wdata;
        end else if (obs_we !== mc_req_we || obs_len !== mc_req_len ||
                     obs_addr !== mc_req_addr || obs_wdata !== mc_req_wdata) begin
          obs_stable = 1'b0;
        end
        if (obs_valid == ack_after) begin
          mc_ack = 1'b1; mc_rdata = rdata;
        end
      end
      @(posedge clk); #1;
      mc_ack = 1'b0; mc_rdata = $urandom;
    end
    @(posedge clk); #1;
    ex_mem_op = NONE;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; mc_ack = 1'b0; mc_rdata = '0;
    ex_mem_op = NONE; ex_reg_addr = 5'd3; ex_reg_data = 32'h55; ex_if_write = 1'b1;
    ex_mem_addr = '0; ex_store_data = '0;
    #2;
    n_checks++; if (mc_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", mc_req_valid); end
    n_checks++; if (mem_stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", mem_stall_req); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    ex_mem_op = NONE; ex_reg_addr = 5'd5; ex_reg_data = 32'h1234; ex_if_write = 1'b1;
    #1;
    n_checks++; if (mem_reg_data !== 32'h1234) begin n_fail++; $display("FAIL pass_data got %h want 00001234", mem_reg_data); end
    n_checks++; if (mem_reg_addr !== 5'd5) begin n_fail++; $display("FAIL pass_addr got %0d want 5", mem_reg_addr); end
    n_checks++; if (mem_stall_req !== 1'b0) begin n_fail++; $display("FAIL pass_stall got %b want 0", mem_stall_req); end
    for (int i = 0; i < 6; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      logic        w;
      a = 5'($urandom); d = $urandom; w = 1'($urandom);
      ex_reg_addr = a; ex_reg_data = d; ex_if_write = w;
      #1;
      n_checks++;
      if (mem_reg_addr !== a || mem_reg_data !== d || if_write !== w || mem_stall_req !== 1'b0) begin
        n_fail++;
        $display("FAIL pass_rand got %0d/%h/%b/%b want %0d/%h/%b/0", mem_reg_addr, mem_reg_data,
                 if_write, mem_stall_req, a, d, w);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lb_lbu();
    do_mem(LB, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0000_00F0, 3);
    n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL lb_timeout got %b want 0", obs_timeout); end
    n_checks++; if (obs_stall != 4) begin n_fail++; $display("FAIL lb_stall_cycles got %0d want 4", obs_stall); end
    n_checks++; if (obs_data !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL lb_data got %h want fffffff0", obs_data); end
    n_checks++; if (obs_rd !== 5'd7 || obs_wr !== 1'b1) begin n_fail++; $display("FAIL lb_wb got %0d/%b want 7/1", obs_rd, obs_wr); end
    n_checks++; if (obs_len !== 2'd0 || obs_we !== 1'b0) begin n_fail++; $display("FAIL lb_req got len %0d we %b want 0/0", obs_len, obs_we); end
    do_mem(LBU, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0000_00F0, 3);
    n_checks++; if (obs_data !== 32'h0000_00F0) begin n_fail++; $display("FAIL lbu_data got %h want 000000f0", obs_data); end
  endtask

  task automatic test_store_word();
    do_mem(SW, 32'h200, 32'hDEAD_BEEF, 5'd9, 1'b1, 32'h0, 2);
    n_checks++; if (obs_we !== 1'b1 || obs_len !== 2'd2) begin n_fail++; $display("FAIL sw_req got we %b len %0d want 1/2", obs_we, obs_len); end
    n_checks++; if (obs_wdata !== 32'hDEAD_BEEF || obs_addr !== 32'h200) begin n_fail++; $display("FAIL sw_req got %h@%h want deadbeef@00000200", obs_wdata, obs_addr); end
    n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL sw_stable got %b want 1", obs_stable); end
    n_checks++; if (obs_wr !== 1'b0 || obs_rd !== 5'd0 || obs_data !== 32'h0) begin n_fail++; $display("FAIL sw_wb got %b/%0d/%h want 0/0/0", obs_wr, obs_rd, obs_data); end
  endtask

  task automatic test_ready_freeze();
    ex_mem_op = LW; ex_mem_addr = 32'h340; ex_reg_addr = 5'd12; ex_if_write = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (mc_req_valid !== 1'b1 || mc_req_addr !== 32'h340 || mem_stall_req !== 1'b1) begin
        n_fail++;
        $display("FAIL rdy_hold got valid %b addr %h stall %b want 1/00000340/1", mc_req_valid, mc_req_addr, mem_stall_req);
      end
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    @(negedge clk);
    mc_ack = 1'b1; mc_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mc_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_stall_req !== 1'b0 || mem_reg_data !== 32'hCAFE_F00D || mem_reg_addr !== 5'd12) begin
      n_fail++;
      $display("FAIL rdy_resume got stall %b data %h rd %0d want 0/cafef00d/12", mem_stall_req, mem_reg_data, mem_reg_addr);
    end
    @(posedge clk); #1;
    ex_mem_op = NONE;
  endtask

  task automatic test_reset_mid_wait();
    ex_mem_op = LH; ex_mem_addr = 32'h402; ex_reg_addr = 5'd4; ex_if_write = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (mc_req_valid !== 1'b1) begin n_fail++; $display("FAIL rstw_pre got %b want 1", mc_req_valid); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (mc_req_valid !== 1'b0 || mem_stall_req !== 1'b0) begin n_fail++; $display("FAIL rstw_async got valid %b stall %b want 0/0", mc_req_valid, mem_stall_req); end
    @(posedge clk); #1;
    ex_mem_op = NONE; ex_if_write = 1'b0; rst = 1'b0;
    mc_ack = 1'b1; mc_rdata = 32'h1111_2222;
    @(negedge clk);
    n_checks++; if (mc_req_valid !== 1'b0 || if_write !== 1'b0) begin n_fail++; $display("FAIL rstw_stray got valid %b wr %b want 0/0", mc_req_valid, if_write); end
    @(posedge clk); #1;
    mc_ack = 1'b0;
    // A fresh op must traverse IDLE and WAIT; a leftover DONE would skip the stall
    do_mem(LW, 32'h404, 32'h0, 5'd6, 1'b1, 32'h0BAD_CAFE, 1);
    n_checks++; if (obs_stall != 2 || obs_data !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL rstw_next got stall %0d data %h want 2/0badcafe", obs_stall, obs_data); end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_CHK_EN
    do_mem(LW, 32'h102, 32'h0, 5'd8, 1'b1, 32'h0, 1);
    n_checks++; if (obs_valid != 0) begin n_fail++; $display("FAIL mis_valid got %0d want 0", obs_valid); end
    n_checks++; if (obs_stall != 1) begin n_fail++; $display("FAIL mis_stall got %0d want 1", obs_stall); end
    n_checks++; if (obs_wr !== 1'b0) begin n_fail++; $display("FAIL mis_wr got %b want 0", obs_wr); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got %b want 1", misalign_err); end
`else
    do_mem(LW, 32'h102, 32'h0, 5'd8, 1'b1, 32'h7654_3210, 1);
    n_checks++; if (obs_addr !== 32'h102 || obs_valid != 1) begin n_fail++; $display("FAIL mis_pass got %h/%0d want 00000102/1", obs_addr, obs_valid); end
    n_checks++; if (misalign_err !== 1'b0 || obs_data !== 32'h7654_3210) begin n_fail++; $display("FAIL mis_off got err %b data %h want 0/76543210", misalign_err, obs_data); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [8];
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] addr, sdata, rdata, exp_d;
      logic [4:0]  rd, exp_rd;
      logic        ifw, exp_wr;
      int          lat;
      op = ops[$urandom_range(0, 7)];
      addr = $urandom & 32'hFFFF_FFFC;
      if (m_len(op) == 2'd0) addr = addr + $urandom_range(0, 3);
      if (m_len(op) == 2'd1) addr = addr + 2 * $urandom_range(0, 1);
      sdata = $urandom; rdata = $urandom; rd = 5'($urandom); ifw = 1'($urandom);
      lat = $urandom_range(1, 4);
      do_mem(op, addr, sdata, rd, ifw, rdata, lat);
      exp_rd = m_store(op) ? 5'd0 : rd;
      exp_d  = m_store(op) ? 32'd0 : m_load(op, rdata);
      exp_wr = m_store(op) ? 1'b0 : ifw;
      n_checks++;
      if (obs_timeout !== 1'b0 || obs_stall != lat + 1 || obs_stable !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_timing op %0d got stall %0d stable %b to %b want %0d/1/0", op, obs_stall, obs_stable, obs_timeout, lat + 1);
      end
      n_checks++;
      if (obs_we !== m_store(op) || obs_len !== m_len(op) || obs_addr !== addr ||
          obs_wdata !== (m_store(op) ? m_wdata(op, sdata) : obs_wdata)) begin
        n_fail++;
        $display("FAIL b2b_req op %0d got we %b len %0d addr %h wd %h want %b/%0d/%h/%h", op, obs_we, obs_len,
                 obs_addr, obs_wdata, m_store(op), m_len(op), addr, m_wdata(op, sdata));
      end
      n_checks++;
      if (obs_rd !== exp_rd || obs_data !== exp_d || obs_wr !== exp_wr) begin
        n_fail++;
        $display("FAIL b2b_wb op %0d got %0d/%h/%b want %0d/%h/%b", op, obs_rd, obs_data, obs_wr, exp_rd, exp_d, exp_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lb_lbu();
    test_store_word();
    test_ready_freeze();
    test_reset_mid_wait();
    test_misalign();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
